// File: rtl/sipo_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Words are delivered on data_out with one-cycle data_valid/parity_err/frame_err pulses.
module sipo_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for a low start bit
  // DATA      | shifting in data bits, LSB first
  // PARITY    | sampling the even-parity bit
  // STOP      | sampling the stop bit, deliver or flag framing error
  // WAIT_HIGH | after a framing error, wait for the line to return high
  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par_acc;
  logic             r_par_mis;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_parity_err;
  logic             r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_acc    <= 1'b0;
      r_par_mis    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      // Pulses drop on the next edge regardless of the strobe.
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (sin_en) begin
        case (r_state)
          S_IDLE: begin
            if (!sin) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              r_par_acc <= 1'b0;
              r_par_mis <= 1'b0;
            end
          end
          S_DATA: begin
            r_shift[r_bit_cnt] <= sin;
            r_par_acc          <= r_par_acc ^ sin;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= PARITY_EN ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            r_par_mis <= sin ^ r_par_acc;
            r_state   <= S_STOP;
          end
          S_STOP: begin
            if (sin) begin
              r_data_out   <= r_shift;
              r_data_valid <= 1'b1;
              r_parity_err <= r_par_mis;
              r_state      <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end
          S_WAIT_HIGH: begin
            if (sin) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE);

endmodule
